// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the board-side switches and cpu_clk_ctrl.
// cyc_cnt is present only when CLK_CTRL_CYCLE_CNT_EN is defined.
interface cpu_clk_ctrl_if #(
  parameter int DIV_W = 32
);
  logic             run;
  logic             step_req;
  logic             sw_slow;
  logic [DIV_W-1:0] clkdiv;
  logic             Clk_CPU;
  logic             cpu_tick;
  logic             step_ack;
  logic [1:0]       state;
`ifdef CLK_CTRL_CYCLE_CNT_EN
  logic [31:0]      cyc_cnt;

  modport master (
    output run, step_req, sw_slow,
    input  clkdiv, Clk_CPU, cpu_tick, step_ack, state, cyc_cnt
  );

  modport slave (
    input  run, step_req, sw_slow,
    output clkdiv, Clk_CPU, cpu_tick, step_ack, state, cyc_cnt
  );
`else
  modport master (
    output run, step_req, sw_slow,
    input  clkdiv, Clk_CPU, cpu_tick, step_ack, state
  );

  modport slave (
    input  run, step_req, sw_slow,
    output clkdiv, Clk_CPU, cpu_tick, step_ack, state
  );
`endif
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step controller: free-running divider, fast/slow tap select, glitch-free gated Clk_CPU.
// Define CLK_CTRL_CYCLE_CNT_EN to add the cyc_cnt output counting cpu_tick pulses since reset.
module cpu_clk_ctrl #(
  parameter int DIV_W    = 32,
  parameter int FAST_TAP = 2,
  parameter int SLOW_TAP = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_clk_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_HALT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  logic [DIV_W-1:0] r_clkdiv;
  logic [1:0]       r_run_sync;
  logic [1:0]       r_sel_sync;
  logic             r_active_sel;
  logic             r_tap_d;
  logic             r_clk_cpu;
  logic             r_cpu_tick;
  logic             r_step_ack;
  state_t           r_state;

  logic             w_run_s;
  logic             w_sel_s;
  logic             w_sel_diff;
  logic             w_tap;
  logic             w_gate_open;
  logic             w_tap_follow;
  logic             w_clk_nxt;
  logic             w_idle_low;

  // Tap selection and the gated next value of Clk_CPU.
  always_comb begin
    w_run_s     = r_run_sync[1];
    w_sel_s     = r_sel_sync[1];
    w_sel_diff  = w_sel_s ^ r_active_sel;
    if (r_active_sel) begin
      w_tap = r_clkdiv[SLOW_TAP];
    end else begin
      w_tap = r_clkdiv[FAST_TAP];
    end
    w_gate_open = (r_state == ST_RUN) || (r_state == ST_STEP);
    // A low Clk_CPU may only rise on a real tap 0->1 step, never part-way into a tap high phase.
    if (r_clk_cpu) begin
      w_tap_follow = w_tap;
    end else begin
      w_tap_follow = w_tap & ~r_tap_d;
    end
    w_clk_nxt  = w_gate_open & w_tap_follow;
    w_idle_low = ~r_clk_cpu & ~w_tap;
  end

  // Free-running divider, delayed tap and input synchronisers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clkdiv   <= {DIV_W{1'b0}};
      r_tap_d    <= 1'b0;
      r_run_sync <= 2'b00;
      r_sel_sync <= 2'b00;
    end else begin
      r_clkdiv   <= r_clkdiv + {{(DIV_W-1){1'b0}}, 1'b1};
      r_tap_d    <= w_tap;
      r_run_sync <= {r_run_sync[0], io_bus.run};
      r_sel_sync <= {r_sel_sync[0], io_bus.sw_slow};
    end
  end

  // Run/halt/step/switch FSM with registered clock, tick and ack outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_HALT;
      r_active_sel <= 1'b0;
      r_clk_cpu    <= 1'b0;
      r_cpu_tick   <= 1'b0;
      r_step_ack   <= 1'b0;
    end else begin
      r_clk_cpu  <= w_clk_nxt;
      r_cpu_tick <= w_clk_nxt & ~r_clk_cpu;
      r_step_ack <= 1'b0;
      case (r_state)
        ST_HALT: begin
          if (w_sel_diff) begin
            r_state      <= ST_SWITCH;
            r_active_sel <= w_sel_s;
          end else if (w_run_s) begin
            r_state <= ST_RUN;
          end else if (io_bus.step_req) begin
            r_state <= ST_STEP;
          end else begin
            r_state <= ST_HALT;
          end
        end
        ST_RUN: begin
          if (w_idle_low && w_sel_diff) begin
            r_state      <= ST_SWITCH;
            r_active_sel <= w_sel_s;
          end else if (w_idle_low && !w_run_s) begin
            r_state <= ST_HALT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_STEP: begin
          // The step is complete once its single high phase falls.
          if (r_clk_cpu && !w_tap) begin
            r_state    <= ST_HALT;
            r_step_ack <= 1'b1;
          end else begin
            r_state <= ST_STEP;
          end
        end
        ST_SWITCH: begin
          if (!w_tap) begin
            r_state <= w_run_s ? ST_RUN : ST_HALT;
          end else begin
            r_state <= ST_SWITCH;
          end
        end
        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  assign io_bus.clkdiv   = r_clkdiv;
  assign io_bus.Clk_CPU  = r_clk_cpu;
  assign io_bus.cpu_tick = r_cpu_tick;
  assign io_bus.step_ack = r_step_ack;
  assign io_bus.state    = r_state;

`ifdef CLK_CTRL_CYCLE_CNT_EN
  logic [31:0] r_cyc_cnt;

  // Count of cpu_tick pulses since reset, updated on the edge that raises cpu_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt <= 32'd0;
    end else if (w_clk_nxt && !r_clk_cpu) begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
    end else begin
      r_cyc_cnt <= r_cyc_cnt;
    end
  end

  assign io_bus.cyc_cnt = r_cyc_cnt;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: per-cycle behavioural model plus directed and random stimulus.
module tb_cpu_clk_ctrl;
  localparam int DIV_W    = 32;
  localparam int FAST_TAP = 2;
  localparam int SLOW_TAP = 4;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_SWITCH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cpu_clk_ctrl_if #(.DIV_W(DIV_W)) bus ();

  cpu_clk_ctrl #(.DIV_W(DIV_W), .FAST_TAP(FAST_TAP), .SLOW_TAP(SLOW_TAP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_cnt;
  logic [31:0] m_cyc;
  int          m_state;
  bit          m_clk, m_tick, m_ack, m_asel;
  bit          run_q[2];
  bit          sel_q[2];

  function automatic bit tap_of(input logic [31:0] c, input bit slow);
    return slow ? c[SLOW_TAP] : c[FAST_TAP];
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    bit run_s, sel_s, tap, tap_prev, nxt;
    if (!rst_n) begin
      m_cnt = 32'd0; m_cyc = 32'd0; m_state = M_HALT;
      m_clk = 1'b0; m_tick = 1'b0; m_ack = 1'b0; m_asel = 1'b0;
      run_q[0] = 1'b0; run_q[1] = 1'b0; sel_q[0] = 1'b0; sel_q[1] = 1'b0;
    end else begin
      run_s    = run_q[1];
      sel_s    = sel_q[1];
      tap      = tap_of(m_cnt, m_asel);
      tap_prev = tap_of(m_cnt - 32'd1, m_asel);
      // Gate open in RUN/STEP: follow the tap one clk late, but rise only on a true tap rising step.
      nxt   = 1'b0;
      m_ack = 1'b0;
      if (m_state == M_RUN || m_state == M_STEP) nxt = m_clk ? tap : (tap && !tap_prev);
      case (m_state)
        M_HALT: begin
          if (sel_s != m_asel) begin m_state = M_SWITCH; m_asel = sel_s; end
          else if (run_s) m_state = M_RUN;
          else if (bus.step_req) m_state = M_STEP;
        end
        M_RUN: begin
          if (!m_clk && !tap) begin
            if (sel_s != m_asel) begin m_state = M_SWITCH; m_asel = sel_s; end
            else if (!run_s) m_state = M_HALT;
          end
        end
        M_STEP: begin
          if (m_clk && !tap) begin m_state = M_HALT; m_ack = 1'b1; end
        end
        default: begin
          if (!tap) m_state = run_s ? M_RUN : M_HALT;
        end
      endcase
      m_tick = nxt && !m_clk;
      m_clk  = nxt;
      if (m_tick) m_cyc = m_cyc + 32'd1;
      m_cnt    = m_cnt + 32'd1;
      run_q[1] = run_q[0]; run_q[0] = bus.run;
      sel_q[1] = sel_q[0]; sel_q[0] = bus.sw_slow;
    end
  end

  // ---------------- compare + phase monitor ----------------
  int cur_len = 0, hi_last = 0, lo_last = 0, falls = 0;
  int ticks = 0, ticks_rst = 0, acks = 0, cyc_no = 0, last_tick_cyc = 0, tick_gap = 0;
  bit prev_clk = 1'b0, seen_step = 1'b0, seen_switch = 1'b0;

  always @(negedge clk) begin
    chk("clkdiv",   64'(bus.clkdiv),   64'(m_cnt));
    chk("Clk_CPU",  64'(bus.Clk_CPU),  64'(m_clk));
    chk("cpu_tick", 64'(bus.cpu_tick), 64'(m_tick));
    chk("step_ack", 64'(bus.step_ack), 64'(m_ack));
    chk("state",    64'(bus.state),    64'(m_state));
`ifdef CLK_CTRL_CYCLE_CNT_EN
    chk("cyc_cnt",  64'(bus.cyc_cnt),  64'(m_cyc));
`endif
    if (!rst_n) begin
      cur_len = 0; prev_clk = 1'b0; ticks_rst = 0;
    end else begin
      cyc_no++;
      if (bus.Clk_CPU == prev_clk) begin
        cur_len++;
      end else begin
        if (prev_clk) begin
          hi_last = cur_len; falls++;
          chk("high_phase_full", 64'(cur_len == 4 || cur_len == 16), 64'd1);
        end else begin
          lo_last = cur_len;
          chk("low_phase_min", 64'(cur_len >= 4), 64'd1);
        end
        cur_len = 1;
        prev_clk = bus.Clk_CPU;
      end
      if (bus.cpu_tick) begin
        ticks++; ticks_rst++;
        tick_gap = cyc_no - last_tick_cyc;
        last_tick_cyc = cyc_no;
      end
      if (bus.step_ack) acks++;
      if (bus.state == 2'd2) seen_step = 1'b1;
      if (bus.state == 2'd3) seen_switch = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
    int n = 0;
    while (bus.state !== s && n < budget) begin tick_n(1); n++; end
    chk(nm, 64'(bus.state), 64'(s));
  endtask

  task automatic wait_tick(input string nm);
    int n = 0;
    while (bus.cpu_tick !== 1'b1 && n < 40) begin tick_n(1); n++; end
    chk(nm, 64'(bus.cpu_tick), 64'd1);
  endtask

  task automatic wait_fall(input string nm);
    int f0 = falls;
    int n  = 0;
    while (falls == f0 && n < 40) begin tick_n(1); n++; end
    chk(nm, 64'(falls - f0), 64'd1);
  endtask

  initial begin
    int t0, a0;
    bus.run = 1'b0; bus.step_req = 1'b0; bus.sw_slow = 1'b0;
    rst_n = 1'b0;
    tick_n(3);
    rst_n = 1'b1;

    // 1: idle after reset
    tick_n(100);
    chk("t1_clkdiv", 64'(bus.clkdiv), 64'd100);
    chk("t1_clk",    64'(bus.Clk_CPU), 64'd0);
    chk("t1_state",  64'(bus.state), 64'd0);
    chk("t1_ticks",  64'(ticks), 64'd0);

    // 2: fast free run
    bus.run = 1'b1;
    tick_n(40);
    chk("t2_state", 64'(bus.state), 64'd1);
    chk("t2_high",  64'(hi_last), 64'd4);
    chk("t2_low",   64'(lo_last), 64'd4);
    chk("t2_gap",   64'(tick_gap), 64'd8);

    // 3: single step, second request during STEP ignored
    bus.run = 1'b0;
    wait_state(2'd0, 40, "t3_halt");
    t0 = ticks; a0 = acks;
    bus.step_req = 1'b1; tick_n(1); bus.step_req = 1'b0;
    tick_n(1);
    chk("t3_in_step", 64'(bus.state), 64'd2);
    bus.step_req = 1'b1; tick_n(1); bus.step_req = 1'b0;
    tick_n(30);
    chk("t3_one_tick", 64'(ticks - t0), 64'd1);
    chk("t3_one_ack",  64'(acks - a0), 64'd1);
    chk("t3_high",     64'(hi_last), 64'd4);
    chk("t3_halt_end", 64'(bus.state), 64'd0);

    // 4: fast -> slow switch requested mid high phase
    bus.run = 1'b1;
    wait_state(2'd1, 10, "t4_run");
    wait_tick("t4_rise");
    tick_n(1);
    seen_switch = 1'b0;
    bus.sw_slow = 1'b1;
    wait_fall("t4_fall");
    chk("t4_high_kept", 64'(hi_last), 64'd4);
    tick_n(200);
    chk("t4_switch_seen", 64'(seen_switch), 64'd1);
    chk("t4_slow_high",   64'(hi_last), 64'd16);
    chk("t4_slow_low",    64'(lo_last), 64'd16);

    // 5: halt at a rise, then run and step_req coinciding at the FSM
    bus.sw_slow = 1'b0;
    tick_n(80);
    chk("t5_fast_again", 64'(hi_last), 64'd4);
    wait_tick("t5_rise");
    bus.run = 1'b0;
    wait_fall("t5_fall");
    chk("t5_high", 64'(hi_last), 64'd4);
    wait_state(2'd0, 10, "t5_halt");
    t0 = ticks;
    tick_n(20);
    chk("t5_clk_low", 64'(bus.Clk_CPU), 64'd0);
    chk("t5_no_tick", 64'(ticks - t0), 64'd0);
    a0 = acks;
    bus.run = 1'b1;
    tick_n(2);
    bus.step_req = 1'b1; tick_n(1); bus.step_req = 1'b0;
    chk("t5_run_wins", 64'(bus.state), 64'd1);
    tick_n(30);
    chk("t5_no_ack", 64'(acks - a0), 64'd0);

    // 6: asynchronous reset mid high phase
    wait_tick("t6_rise");
    tick_n(1);
    rst_n = 1'b0;
    #1;
    chk("t6_clk_async",   64'(bus.Clk_CPU), 64'd0);
    chk("t6_state_async", 64'(bus.state), 64'd0);
`ifdef CLK_CTRL_CYCLE_CNT_EN
    chk("t6_cyc_reset", 64'(bus.cyc_cnt), 64'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick_n(80);
    chk("t6_clkdiv",    64'(bus.clkdiv), 64'd80);
    chk("t6_ten_ticks", 64'(ticks_rst), 64'd10);
`ifdef CLK_CTRL_CYCLE_CNT_EN
    chk("t6_cyc_ten", 64'(bus.cyc_cnt), 64'd10);
`endif

    // random run/slow/step traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.step_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 79) == 0) bus.sw_slow = ~bus.sw_slow;
      tick_n(1);
    end
    bus.step_req = 1'b0;
    tick_n(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
